// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers for the write-side and read-side controllers.
// Gray/binary conversion is width-generic: callers pass PTR_SZ and the helpers
// work on PTR_SZ+1 bits inside a fixed-width word.
package fifo_pkg;

  localparam int unsigned FIFO_PTR_SZ_DEF = 2;
  localparam int unsigned GRAY_MAX_W      = 32;

  typedef logic [GRAY_MAX_W-1:0] ptr_word_t;

  // Mask covering the PTR_SZ+1 pointer bits.
  function automatic ptr_word_t ptr_mask(input int unsigned ptr_sz);
    return (ptr_word_t'(1) << (ptr_sz + 1)) - ptr_word_t'(1);
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t b, input int unsigned ptr_sz);
    ptr_word_t m;
    m = b & ptr_mask(ptr_sz);
    return m ^ (m >> 1);
  endfunction

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic ptr_word_t gray2bin(input ptr_word_t g, input int unsigned ptr_sz);
    ptr_word_t m;
    ptr_word_t b;
    m = g & ptr_mask(ptr_sz);
    b = '0;
    for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
      b = b ^ (m >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side FIFO bundle: upstream request/clear, cross-domain pointers,
// RAM write port and status flags.
// master: upstream + read side (drives winc, wovf_clr, rptr_gray)
// slave : fifo_wptr_full (drives write_en, waddr, wptr_gray, flags, wlevel)
interface fifo_wptr_full_if
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_SZ = FIFO_PTR_SZ_DEF
);

  logic              winc;
  logic              wovf_clr;
  logic [PTR_SZ:0]   rptr_gray;
  logic              write_en;
  logic [PTR_SZ-1:0] waddr;
  logic [PTR_SZ:0]   wptr_gray;
  logic              wfull;
  logic              walmost_full;
  logic [PTR_SZ:0]   wlevel;
  logic              woverflow;

  modport master (
    output winc, wovf_clr, rptr_gray,
    input  write_en, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wovf_clr, rptr_gray,
    output write_en, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow
  );

endinterface

// File: rtl/sync_2ff.sv
// W-bit two-flop synchroniser, async active-high reset to 0.
// Ports: clk, rst, d_i (asynchronous input), q_o (synchronised output).
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q1_q;
  logic [W-1:0] q2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= d_i;
      q2_q <= q1_q;
    end
  end

  assign q_o = q2_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and flag controller for the dual-clock FIFO.
// Ports: clk, rst (async, active-high), bus (fifo_wptr_full_if.slave):
//   in : winc, wovf_clr, rptr_gray (read-domain Gray pointer)
//   out: write_en (comb), waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_SZ       = FIFO_PTR_SZ_DEF,
  parameter int unsigned AFULL_THRESH = (2 ** PTR_SZ) - 1
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wptr_full_if.slave  bus
);

  localparam int unsigned PTR_W = PTR_SZ + 1;

  logic [PTR_W-1:0] wbin_q,   wbin_d;
  logic [PTR_W-1:0] wgray_q,  wgray_d;
  logic [PTR_W-1:0] wlevel_q, wlevel_d;
  logic             wfull_q,  wfull_d;
  logic             wafull_q, wafull_d;
  logic             wovf_q,   wovf_d;
  logic [PTR_W-1:0] rq2;
  logic [PTR_W-1:0] rbin_sync;
  logic             wr_accept_c;

  // Read pointer crosses into the write domain only through this synchroniser.
  sync_2ff #(.W(PTR_W)) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rptr_gray),
    .q_o (rq2)
  );

  // Next pointer, flags and level; full compares against the read pointer
  // with its two MSBs inverted (one lap ahead).
  always_comb begin
    wr_accept_c = 1'b0;
    wbin_d      = wbin_q;
    wgray_d     = wgray_q;
    rbin_sync   = '0;
    wlevel_d    = wlevel_q;
    wfull_d     = wfull_q;
    wafull_d    = wafull_q;
    wovf_d      = wovf_q;

    wr_accept_c = bus.winc & ~wfull_q;
    wbin_d      = wbin_q + PTR_W'(wr_accept_c);
    wgray_d     = PTR_W'(bin2gray(ptr_word_t'(wbin_d), PTR_SZ));
    rbin_sync   = PTR_W'(gray2bin(ptr_word_t'(rq2), PTR_SZ));
    wfull_d     = (wgray_d == {~rq2[PTR_SZ:PTR_SZ-1], rq2[PTR_SZ-2:0]});
    wlevel_d    = wbin_d - rbin_sync;
    wafull_d    = (wlevel_d >= PTR_W'(AFULL_THRESH));
    // Set beats clear when both happen in the same cycle.
    wovf_d      = (wovf_q & ~bus.wovf_clr) | (bus.winc & wfull_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign bus.write_en     = wr_accept_c;
  assign bus.waddr        = wbin_q[PTR_SZ-1:0];
  assign bus.wptr_gray    = wgray_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = wafull_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.woverflow    = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (PTR_SZ=2, AFULL_THRESH=3).
// Reference model tracks write/read counts as plain integers; the read count
// seen by the write side is the value sampled two clock edges earlier.
module tb_fifo_wptr_full;

  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_wptr_full_if #(.PTR_SZ(2)) bus ();

  fifo_wptr_full #(.PTR_SZ(2), .AFULL_THRESH(AF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  int m_w, m_r1, m_r2, m_lvl, rcount;
  bit m_full, m_af, m_ovf;
  bit cur_winc, cur_clr;
  int we_cnt;
  logic [2:0] prev_g;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int g8(input int v);
    int b;
    b = v % 8;
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_w = 0; m_r1 = 0; m_r2 = 0; m_lvl = 0; rcount = 0;
    m_full = 0; m_af = 0; m_ovf = 0; prev_g = 3'b000;
  endtask

  // One write-clock edge of the reference behaviour.
  task automatic model_edge();
    bit wr;
    wr     = cur_winc && !m_full;
    m_ovf  = (m_ovf && !cur_clr) || (cur_winc && m_full);
    m_w    = m_w + int'(wr);
    m_lvl  = m_w - m_r2;
    m_full = (m_lvl == DEPTH);
    m_af   = (m_lvl >= AF);
    m_r2   = m_r1;
    m_r1   = rcount;
  endtask

  task automatic check_outputs();
    chk("waddr",  32'(bus.waddr),        32'(m_w % DEPTH));
    chk("wgray",  32'(bus.wptr_gray),    32'(g8(m_w)));
    chk("wfull",  32'(bus.wfull),        32'(m_full));
    chk("wafull", 32'(bus.walmost_full), 32'(m_af));
    chk("wlevel", 32'(bus.wlevel),       32'(m_lvl));
    chk("wovf",   32'(bus.woverflow),    32'(m_ovf));
    chk("lvl_max", 32'(bus.wlevel <= 3'd4), 32'(1));
    chk("gray_step", 32'($countones(bus.wptr_gray ^ prev_g) <= 1), 32'(1));
    prev_g = bus.wptr_gray;
  endtask

  // Check last edge's results, drive new inputs, run one edge.
  task automatic cycle(input bit winc, input bit clr, input int rc);
    @(negedge clk);
    check_outputs();
    cur_winc = winc; cur_clr = clr; rcount = rc;
    bus.winc = winc; bus.wovf_clr = clr; bus.rptr_gray = 3'(g8(rc));
    #1;
    chk("write_en", 32'(bus.write_en), 32'(winc && !m_full));
    if (bus.write_en) we_cnt++;
    @(posedge clk);
    model_edge();
  endtask

  // Mid-cycle asynchronous reset; outputs must clear with no clock edge.
  task automatic reset_pulse();
    #2;
    bus.winc = 1'b0; bus.wovf_clr = 1'b0; bus.rptr_gray = 3'b000;
    cur_winc = 0; cur_clr = 0;
    rst = 1'b1;
    #1;
    chk("rst_gray",  32'(bus.wptr_gray),    32'(0));
    chk("rst_waddr", 32'(bus.waddr),        32'(0));
    chk("rst_full",  32'(bus.wfull),        32'(0));
    chk("rst_afull", 32'(bus.walmost_full), 32'(0));
    chk("rst_lvl",   32'(bus.wlevel),       32'(0));
    chk("rst_ovf",   32'(bus.woverflow),    32'(0));
    chk("rst_we",    32'(bus.write_en),     32'(0));
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    int rc;
    rst = 1'b1;
    bus.winc = 1'b0; bus.wovf_clr = 1'b0; bus.rptr_gray = 3'b000;
    cur_winc = 0; cur_clr = 0; we_cnt = 0;
    model_reset();
    #2;
    chk("init_gray", 32'(bus.wptr_gray), 32'(0));
    chk("init_full", 32'(bus.wfull),     32'(0));
    #1 rst = 1'b0;

    // Fill
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 0);
    #1;
    chk("fill_gray", 32'(bus.wptr_gray),    32'(3'b110));
    chk("fill_full", 32'(bus.wfull),        32'(1));
    chk("fill_lvl",  32'(bus.wlevel),       32'(4));
    chk("fill_af",   32'(bus.walmost_full), 32'(1));

    // Overflow and clear priority
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    #1;
    chk("ovf_set",  32'(bus.woverflow), 32'(1));
    chk("ovf_hold", 32'(bus.wptr_gray), 32'(3'b110));
    cycle(1'b1, 1'b1, 0);
    #1 chk("ovf_setwins", 32'(bus.woverflow), 32'(1));
    cycle(1'b0, 1'b1, 0);
    #1 chk("ovf_clr", 32'(bus.woverflow), 32'(0));

    // Drain visibility: two-edge latency before full drops
    cycle(1'b0, 1'b0, 1);
    #1 chk("drain_n", 32'(bus.wfull), 32'(1));
    cycle(1'b0, 1'b0, 1);
    #1 chk("drain_n1", 32'(bus.wfull), 32'(1));
    cycle(1'b0, 1'b0, 1);
    #1;
    chk("drain_n2_full", 32'(bus.wfull),        32'(0));
    chk("drain_n2_lvl",  32'(bus.wlevel),       32'(3));
    chk("drain_n2_af",   32'(bus.walmost_full), 32'(1));

    // Back-pressure from a clean reset
    reset_pulse();
    we_cnt = 0;
    for (int i = 0; i < 10; i++) cycle(1'(i % 2 == 0), 1'b0, 0);
    chk("bp_pulses", 32'(we_cnt), 32'(4));

    // Random reader
    reset_pulse();
    rc = 0;
    for (int i = 0; i < 200; i++) begin
      if (rc < m_w && $urandom_range(0, 99) < 50) rc++;
      cycle(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 10), rc);
      if (i == 120) begin
        reset_pulse();
        rc = 0;
      end
    end

    // Reader tracking two entries behind, across several wraps
    for (int i = 0; i < 40; i++) begin
      if (m_w - 2 > rc) rc = m_w - 2;
      cycle(1'b1, 1'b0, rc);
    end
    cycle(1'b0, 1'b0, rc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
